// File: rtl/fbank_pkg.sv
// Shared constants for the mel filterbank LUT reader: parameter defaults,
// coefficient LUT field layout, Q0.11 scaling, accumulator width and FSM encoding.
package fbank_pkg;

  localparam int FFT_BINS_DEF  = 512;
  localparam int NUM_BANDS_DEF = 40;

  localparam int LUT_AW   = 10;
  localparam int LUT_DW   = 17;
  localparam int BAND_MSB = 16;
  localparam int BAND_LSB = 11;
  localparam int W_MSB    = 10;
  localparam int W_LSB    = 0;
  localparam int BAND_W   = BAND_MSB - BAND_LSB + 1;
  localparam int W_W      = W_MSB - W_LSB + 1;

  localparam logic [11:0] Q11_ONE   = 12'd2048;
  localparam int          Q11_SHIFT = 11;
  localparam int          ACC_W     = 54;

  localparam logic [1:0] ST_ACCUM  = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_OUTPUT = 2'd2;

  // Band energy: accumulator rescaled from Q0.11 and clamped to 32 bits.
  function automatic logic [31:0] sat_band(input logic [ACC_W-1:0] acc);
    if (|acc[ACC_W-1:32+Q11_SHIFT]) begin
      sat_band = 32'hFFFF_FFFF;
    end else begin
      sat_band = acc[32+Q11_SHIFT-1:Q11_SHIFT];
    end
  endfunction

endpackage

// File: rtl/fbank_mac.sv
// Triangular-filter weight split: one power sample feeds its own band with w
// and the band below with the complementary weight 2048-w.
module fbank_mac
  import fbank_pkg::*;
#(
  parameter int PWR_W = 32
) (
  input  logic [PWR_W-1:0]     p,
  input  logic [W_W-1:0]       w,
  output logic [PWR_W+W_W-1:0] pw,
  output logic [PWR_W+W_W:0]   pnw
);

  logic [W_W:0] wc;

  assign wc  = Q11_ONE - {1'b0, w};
  assign pw  = {{W_W{1'b0}}, p} * {{PWR_W{1'b0}}, w};
  assign pnw = {{(W_W+1){1'b0}}, p} * {{PWR_W{1'b0}}, wc};

endmodule

// File: rtl/fbank_lut_reader.sv
// Mel filterbank accumulator: walks the coefficient LUT once per power frame,
// accumulates weighted power into per-band sums and streams the band energies out.
module fbank_lut_reader
  import fbank_pkg::*;
#(
  parameter int FFT_BINS  = FFT_BINS_DEF,
  parameter int NUM_BANDS = NUM_BANDS_DEF,
  parameter int PWR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwr_valid,
  input  logic [PWR_W-1:0]  pwr_data,
  input  logic              pwr_last,
  output logic              pwr_ready,
  output logic [LUT_AW-1:0] lut_addr,
  input  logic [LUT_DW-1:0] lut_rd_data,
  output logic              fb_valid,
  output logic [31:0]       fb_data,
  output logic              fb_last,
  input  logic              fb_ready,
  output logic              frame_err
);

  localparam logic [LUT_AW-1:0] LAST_BIN  = LUT_AW'(FFT_BINS - 1);
  localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NUM_BANDS - 1);

  logic [1:0]             state;
  logic                   run;
  logic [LUT_AW-1:0]      bin_cnt;
  logic [BAND_W-1:0]      band_idx;
  logic [PWR_W-1:0]       p_hold;
  logic                   acc_en;
  logic [ACC_W-1:0]       acc [NUM_BANDS];
  logic                   xfer;
  logic                   end_bin;
  logic                   fb_hs;
  logic [BAND_W-1:0]      lut_band;
  logic [W_W-1:0]         lut_w;
  logic [PWR_W+W_W-1:0]   pw;
  logic [PWR_W+W_W:0]     pnw;

  // run keeps pwr_ready low while reset is asserted even though the state is ACCUM
  assign pwr_ready = run && (state == ST_ACCUM);
  assign xfer      = pwr_valid && pwr_ready;
  assign end_bin   = (bin_cnt == LAST_BIN);
  assign lut_addr  = (state == ST_ACCUM) ? bin_cnt : {LUT_AW{1'b0}};
  assign fb_hs     = fb_valid && fb_ready;
  assign lut_band  = lut_rd_data[BAND_MSB:BAND_LSB];
  assign lut_w     = lut_rd_data[W_MSB:W_LSB];

  fbank_mac #(.PWR_W(PWR_W)) u_mac (
    .p   (p_hold),
    .w   (lut_w),
    .pw  (pw),
    .pnw (pnw)
  );

  // Output presentation straight from the held accumulator of the current band.
  always_comb begin
    fb_valid = 1'b0;
    fb_last  = 1'b0;
    fb_data  = 32'd0;
    if (state == ST_OUTPUT) begin
      fb_valid = 1'b1;
      fb_last  = (band_idx == LAST_BAND);
      fb_data  = sat_band(acc[band_idx]);
    end else begin
      fb_valid = 1'b0;
      fb_last  = 1'b0;
      fb_data  = 32'd0;
    end
  end

  // Frame sequencing: bin walk, drain slot, band output walk, frame-length check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ACCUM;
      run       <= 1'b0;
      bin_cnt   <= {LUT_AW{1'b0}};
      band_idx  <= {BAND_W{1'b0}};
      p_hold    <= {PWR_W{1'b0}};
      acc_en    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      run       <= 1'b1;
      acc_en    <= xfer;
      frame_err <= 1'b0;
      if (xfer) begin
        p_hold <= pwr_data;
      end
      case (state)
        ST_ACCUM: begin
          if (xfer) begin
            if (pwr_last || end_bin) begin
              state     <= ST_DRAIN;
              bin_cnt   <= {LUT_AW{1'b0}};
              frame_err <= pwr_last ^ end_bin;
            end else begin
              bin_cnt <= bin_cnt + 10'd1;
            end
          end
        end
        ST_DRAIN: begin
          state    <= ST_OUTPUT;
          band_idx <= {BAND_W{1'b0}};
        end
        ST_OUTPUT: begin
          if (fb_hs) begin
            if (band_idx == LAST_BAND) begin
              state    <= ST_ACCUM;
              band_idx <= {BAND_W{1'b0}};
            end else begin
              band_idx <= band_idx + 6'd1;
            end
          end
        end
        default: begin
          state <= ST_ACCUM;
        end
      endcase
    end
  end

  // Band accumulators; LUT data lines up with p_hold one cycle after the transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        acc[i] <= {ACC_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        if (acc_en && ({1'b0, lut_band} == 7'(i))) begin
          acc[i] <= acc[i] + ACC_W'(pw);
        end else if (acc_en && ({1'b0, lut_band} == 7'(i + 1))) begin
          acc[i] <= acc[i] + ACC_W'(pnw);
        end else if (fb_hs && (band_idx == BAND_W'(i))) begin
          acc[i] <= {ACC_W{1'b0}};
        end
      end
    end
  end

endmodule

// File: tb/tb_fbank_lut_reader.sv
// Randomized self-checking bench for fbank_lut_reader against a per-band
// sum-of-products reference computed directly from the LUT and power samples.
module tb_fbank_lut_reader;

  logic        clk;
  logic        rst_n;
  logic        pwr_valid;
  logic [31:0] pwr_data;
  logic        pwr_last;
  logic        pwr_ready;
  logic [9:0]  lut_addr;
  logic [16:0] lut_rd_data;
  logic        fb_valid;
  logic [31:0] fb_data;
  logic        fb_last;
  logic        fb_ready;
  logic        frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int ferr_seen = 0;
  int exp_err = 0;

  logic [16:0]     lut [0:1023];
  longint unsigned exp_acc [0:39];
  logic [31:0]     obs_band [0:39];

  fbank_lut_reader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwr_valid   (pwr_valid),
    .pwr_data    (pwr_data),
    .pwr_last    (pwr_last),
    .pwr_ready   (pwr_ready),
    .lut_addr    (lut_addr),
    .lut_rd_data (lut_rd_data),
    .fb_valid    (fb_valid),
    .fb_data     (fb_data),
    .fb_last     (fb_last),
    .fb_ready    (fb_ready),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  // Coefficient RAM with a one-cycle synchronous read.
  always @(posedge clk) lut_rd_data <= lut[lut_addr];

  // Count cycles in which frame_err is high.
  always @(negedge clk) if (frame_err === 1'b1) ferr_seen++;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] exp_band(input int i);
    longint unsigned s;
    s = exp_acc[i] >> 11;
    if (s > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
    return s[31:0];
  endfunction

  // mode 0: constant entry, 1: random band 0..41, 2: band 63 with random weight
  task automatic fill_lut(input int mode, input int band, input int w);
    for (int k = 0; k < 1024; k++) begin
      if (mode == 0) lut[k] = {6'(band), 11'(w)};
      else if (mode == 1) lut[k] = {6'($urandom_range(41)), 11'($urandom_range(2047))};
      else lut[k] = {6'd63, 11'($urandom_range(2047))};
    end
  endtask

  task automatic send_frame(input int last_at, input bit prand, input logic [31:0] pconst,
                            input int gap_pct);
    int k, budget, b, wv;
    bit done;
    logic [31:0] pv;
    longint unsigned pl, wl;
    k = 0; budget = 0; done = 1'b0;
    for (int i = 0; i < 40; i++) exp_acc[i] = 0;
    while (!done) begin
      @(negedge clk);
      budget++;
      if (budget > 3000) begin
        check_eq("send_timeout", 64'(k), 64'(512));
        pwr_valid = 1'b0;
        return;
      end
      if (int'($urandom_range(99)) < gap_pct) begin
        pwr_valid = 1'b0;
        pwr_last  = 1'b0;
        continue;
      end
      pv = prand ? $urandom : pconst;
      pwr_valid = 1'b1;
      pwr_data  = pv;
      pwr_last  = (k == last_at);
      if (pwr_ready) begin
        check_eq("lut_addr", 64'(lut_addr), 64'(k));
        b  = int'(lut[k][16:11]);
        wv = int'(lut[k][10:0]);
        pl = 64'(pv);
        wl = 64'(wv);
        if (b < 40) exp_acc[b] += pl * wl;
        if (b >= 1 && b - 1 < 40) exp_acc[b-1] += pl * (64'd2048 - wl);
        if (k == last_at || k == 511) begin
          if ((k == last_at) != (k == 511)) exp_err++;
          done = 1'b1;
        end
        k++;
      end
    end
    @(negedge clk);
    pwr_valid = 1'b0;
    pwr_last  = 1'b0;
  endtask

  task automatic collect(input int ready_pct, input int stall_band, input int stop_at);
    int i, budget, stall_n;
    logic [31:0] held;
    i = 0; budget = 0; stall_n = 0; held = 32'd0;
    while (i < stop_at) begin
      @(negedge clk);
      budget++;
      if (budget > 2000) begin
        check_eq("collect_timeout", 64'(i), 64'(stop_at));
        fb_ready = 1'b0;
        return;
      end
      if (fb_valid) check_eq("pwr_ready_in_output", 64'(pwr_ready), 64'd0);
      if (i == stall_band && stall_n < 10 && (fb_valid || stall_n > 0)) begin
        if (stall_n == 0) held = fb_data;
        else begin
          check_eq("stall_data", 64'(fb_data), 64'(held));
          check_eq("stall_valid", 64'(fb_valid), 64'd1);
        end
        stall_n++;
        fb_ready = 1'b0;
        continue;
      end
      fb_ready = (int'($urandom_range(99)) < ready_pct);
      if (fb_valid && fb_ready) begin
        obs_band[i] = fb_data;
        check_eq($sformatf("fb_data[%0d]", i), 64'(fb_data), 64'(exp_band(i)));
        check_eq($sformatf("fb_last[%0d]", i), 64'(fb_last), 64'(i == 39));
        i++;
      end
    end
    @(negedge clk);
    fb_ready = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    pwr_valid = 1'b0; pwr_data = 32'd0; pwr_last = 1'b0; fb_ready = 1'b0;
    fill_lut(0, 1, 1024);
    repeat (3) @(negedge clk);
    check_eq("rst_pwr_ready", 64'(pwr_ready), 64'd0);
    check_eq("rst_fb_valid", 64'(fb_valid), 64'd0);
    check_eq("rst_fb_data", 64'(fb_data), 64'd0);
    check_eq("rst_fb_last", 64'(fb_last), 64'd0);
    check_eq("rst_frame_err", 64'(frame_err), 64'd0);
    check_eq("rst_lut_addr", 64'(lut_addr), 64'd0);
    rst_n = 1'b1;

    // Uniform split between bands 0 and 1
    send_frame(511, 1'b0, 32'd4, 0);
    collect(100, -1, 40);
    check_eq("t1_band0", 64'(obs_band[0]), 64'd1024);
    check_eq("t1_band1", 64'(obs_band[1]), 64'd1024);
    check_eq("t1_band2", 64'(obs_band[2]), 64'd0);
    check_eq("t1_frame_err", 64'(ferr_seen), 64'(exp_err));

    // Saturation
    fill_lut(0, 5, 2047);
    send_frame(511, 1'b0, 32'hFFFF_FFFF, 20);
    collect(70, -1, 40);
    check_eq("t2_band5_sat", 64'(obs_band[5]), 64'h0000_0000_FFFF_FFFF);
    check_eq("t2_frame_err", 64'(ferr_seen), 64'(exp_err));

    // Short frame with a stall on band 3
    fill_lut(1, 0, 0);
    send_frame(99, 1'b1, 32'd0, 30);
    collect(60, 3, 40);
    check_eq("t3_frame_err", 64'(ferr_seen), 64'(exp_err));
    check_eq("t3_err_count", 64'(exp_err), 64'd1);

    // Out-of-range band field
    fill_lut(2, 0, 0);
    send_frame(511, 1'b1, 32'd0, 10);
    collect(80, -1, 40);
    check_eq("t4_band39", 64'(obs_band[39]), 64'd0);

    // Frame that never raises pwr_last
    fill_lut(1, 0, 0);
    send_frame(-1, 1'b1, 32'd0, 25);
    collect(50, -1, 40);
    check_eq("t5_frame_err", 64'(ferr_seen), 64'(exp_err));

    // Random frame length
    send_frame(int'($urandom_range(510)), 1'b1, 32'd0, 15);
    collect(50, 7, 40);
    check_eq("t6_frame_err", 64'(ferr_seen), 64'(exp_err));

    // Reset in the middle of the band output
    send_frame(511, 1'b1, 32'd0, 0);
    collect(100, -1, 20);
    check_eq("t7_pre_rst_valid", 64'(fb_valid), 64'd1);
    rst_n = 1'b0;
    #2;
    check_eq("t7_rst_fb_valid", 64'(fb_valid), 64'd0);
    check_eq("t7_rst_fb_data", 64'(fb_data), 64'd0);
    check_eq("t7_rst_fb_last", 64'(fb_last), 64'd0);
    check_eq("t7_rst_pwr_ready", 64'(pwr_ready), 64'd0);
    check_eq("t7_rst_lut_addr", 64'(lut_addr), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fill_lut(0, 1, 0);
    send_frame(511, 1'b0, 32'd1, 0);
    collect(100, -1, 40);
    check_eq("t7_band0", 64'(obs_band[0]), 64'd512);
    check_eq("t7_band1", 64'(obs_band[1]), 64'd0);
    check_eq("t7_frame_err", 64'(ferr_seen), 64'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fbank_lut_reader.md
FBANK_LUT_READER -- requirements
Module: fbank_lut_reader

Interface
REQ-001 SHALL have parameter FFT_BINS, default 512, number of power-spectrum bins per frame (2..1024).
REQ-002 SHALL have parameter NUM_BANDS, default 40, number of mel bands (2..64).
REQ-003 SHALL have parameter PWR_W, default 32, power-sample width.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port pwr_valid  input  1  power sample valid.
REQ-007 SHALL have port pwr_data  input  PWR_W  unsigned bin power.
REQ-008 SHALL have port pwr_last  input  1  final bin of frame.
REQ-009 SHALL have port pwr_ready  output  1  block accepts power sample.
REQ-010 SHALL have port lut_addr  output  10  coefficient LUT address.
REQ-011 SHALL have port lut_rd_data  input  17  LUT read data, valid one cycle after lut_addr (unregistered RAM output).
REQ-012 SHALL have port fb_valid  output  1  band energy valid.
REQ-013 SHALL have port fb_data  output  32  band energy.
REQ-014 SHALL have port fb_last  output  1  marks band NUM_BANDS-1.
REQ-015 SHALL have port fb_ready  input  1  downstream accepts band energy.
REQ-016 SHALL have port frame_err  output  1  one-cycle pulse on frame-length mismatch.

Function
REQ-017 SHALL interpret lut_rd_data as {band[16:11], w[10:0]}, w unsigned Q0.11.
REQ-018 SHALL, per accepted bin with power p, add p*w to acc[band] and p*(2048-w) to acc[band-1]; band 0 contributes only the first term; band >= NUM_BANDS contributes nothing.
REQ-019 SHALL hold NUM_BANDS unsigned accumulators of 54 bits each, no wrap (max 1024*(2^32-1)*2048 fits).
REQ-020 SHALL use FSM states ACCUM, DRAIN, OUTPUT; reset state ACCUM.
REQ-021 SHALL assert pwr_ready only in ACCUM; transfer occurs on pwr_valid && pwr_ready.
REQ-022 SHALL drive lut_addr combinationally from bin counter in ACCUM; bin counter increments per transfer, resets to 0 at frame end.
REQ-023 SHALL register p with the transfer and apply REQ-018 in the following cycle (accumulate latency 1 cycle); back-to-back bins to the same band SHALL accumulate correctly every cycle.
REQ-024 SHALL end the frame on the transfer with pwr_last=1 or with bin counter = FFT_BINS-1, whichever occurs first; ACCUM -> DRAIN.
REQ-025 SHALL pulse frame_err when exactly one of (pwr_last=1, bin counter=FFT_BINS-1) holds on the ending transfer.
REQ-026 SHALL stay in DRAIN exactly one cycle (final accumulate), then enter OUTPUT with band index 0.
REQ-027 SHALL, in OUTPUT, present fb_data = min(acc[i] >> 11, 2^32-1), fb_valid=1, fb_last=(i==NUM_BANDS-1); hold stable until fb_valid && fb_ready.
REQ-028 SHALL clear acc[i] on its output handshake and advance i; handshake on last band -> ACCUM.
REQ-029 SHALL never write the LUT; the LUT is preloaded from its init file.

Reset
REQ-030 SHALL on rst_n=0 set state ACCUM, all accumulators 0, bin counter 0, band index 0, pwr_ready 0 during reset, fb_valid 0, fb_last 0, fb_data 0, frame_err 0, lut_addr 0.
REQ-031 SHALL on reset mid-frame or mid-output discard all partial results; first post-reset frame starts at bin 0.

Structure
REQ-032 SHALL place FFT_BINS/NUM_BANDS defaults, LUT field positions, Q0.11 scale (2048), accumulator width 54, and FSM state encoding in shared package fbank_pkg.
REQ-033 SHALL implement the weight split and two products in sub-module fbank_mac (inputs p, w; outputs p*w, p*(2048-w)).

Verification
REQ-034 SHALL test single frame, LUT all {band=1,w=1024}, 512 bins p=4 -> band0 = band1 = 512*4*1024>>11 = 1024, other bands 0, fb_last on band 39.
REQ-035 SHALL test p=2^32-1 all bins, w=2047, band=5 -> band5 saturates to 0xFFFFFFFF.
REQ-036 SHALL test pwr_last at bin 99 (FFT_BINS=512) -> frame_err pulse, 40 bands output, next frame starts at lut_addr 0.
REQ-037 SHALL test fb_ready low 10 cycles during band 3 -> fb_data/fb_valid stable, pwr_ready 0, no lost band.
REQ-038 SHALL test LUT band field 63 (>=NUM_BANDS) -> only band 62 receives p*(2048-w) contribution if 62<NUM_BANDS, else no change.
REQ-039 SHALL test rst_n low mid-OUTPUT at band 20 -> all outputs 0; next frame of p=1,w=0,band=1 -> band0 = 512.
